// File: rtl/multicycle_pkg.sv
// multicycle_pkg: state, opcode and control encodings for the multicycle MIPS controller
package multicycle_pkg;
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b100;
  localparam logic [2:0] ALU_AND   = 3'b111;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b001;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_SHL  = 2'b11;
endpackage

// File: rtl/multicycle_control_mem_watchdog.sv
// mem_watchdog: counts unanswered memory-wait cycles and flags expiry; TIMEOUT_CYCLES=0 disables it
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  input  logic mem_ready,
  output logic expire
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (waiting && !mem_ready) cnt <= cnt + 1'b1;
  assign expire = (TIMEOUT_CYCLES != 0) && waiting && !mem_ready && cnt == TO_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multicycle MIPS datapath with a memory watchdog
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state_o,
  output logic       illegal_op,
  output logic       mem_timeout
);
  state_t state, next;
  logic waiting, expire, is_imm, legal;
  logic [2:0] imm_op;
  assign waiting = state inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
  assign is_imm = opcode inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
  assign legal = is_imm || opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ};
  assign imm_op = opcode == OP_ADDI ? ALU_ADD : opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_SLT;
  assign state_o = state;
  // expire also clears, so a fetch timeout restarts with a fresh count
  mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_wd (
    .clk(clk), .rst(rst), .clear(next != state || expire),
    .waiting(waiting), .mem_ready(mem_ready), .expire(expire)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      illegal_op <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state <= next;
      illegal_op <= state == S_DECODE && !legal;
      mem_timeout <= expire;
    end
  always_comb begin
    next = state;
    case (state)
      S_IDLE:      next = S_FETCH;
      S_FETCH:     next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    next = opcode inside {OP_LW, OP_SW} ? S_MEM_ADDR : opcode == OP_R ? S_EXEC_R :
                          opcode == OP_BEQ ? S_BRANCH : is_imm ? S_EXEC_I : S_FETCH;
      S_MEM_ADDR:  next = opcode == OP_LW ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next = mem_ready ? S_MEM_WB : expire ? S_FETCH : S_MEM_READ;
      S_MEM_WRITE: next = mem_ready || expire ? S_FETCH : S_MEM_WRITE;
      S_MEM_WB, S_R_WB, S_BRANCH, S_I_WB: next = S_FETCH;
      S_EXEC_R:    next = S_R_WB;
      S_EXEC_I:    next = S_I_WB;
      default:     next = S_IDLE;
    endcase
  end
  always_comb begin
    {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA} = '0;
    ALUSrcB = SRCB_REG;
    ALUOp = 3'b000;
    PCSource = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        ALUSrcB = SRCB_FOUR;
        ALUOp = ALU_ADD;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_SHL;
        ALUOp = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp = ALU_ADD;
      end
      S_MEM_READ: {IorD, MemRead} = 2'b11;
      S_MEM_WB: {MemToReg, RegWrite} = 2'b11;
      S_MEM_WRITE: {IorD, MemWrite} = 2'b11;
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp = ALU_FUNCT;
      end
      S_R_WB: {RegDst, RegWrite} = 2'b11;
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
      end
      S_EXEC_I, S_I_WB: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp = imm_op;
        RegWrite = state == S_I_WB;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scripted cycle-by-cycle scoreboard check of the multicycle controller
module tb_multicycle_control;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state_o;
  logic illegal_op, mem_timeout;
  int n_chk = 0, n_pass = 0;
  logic [22:0] exp_q[$];

  multicycle_control #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state_o(state_o), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource
  function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    logic [2:0] iop;
    iop = op == 6'b001000 ? 3'b011 : op == 6'b001100 ? 3'b111 : op == 6'b001101 ? 3'b101 : 3'b001;
    case (st)
      4'd1:  return {rdy, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 4'b0000, 2'b01, 3'b011, 2'b00};
      4'd2:  return {10'b0, 2'b11, 3'b011, 2'b00};
      4'd3:  return {9'b0, 1'b1, 2'b10, 3'b011, 2'b00};
      4'd4:  return {2'b00, 2'b11, 13'b0};
      4'd5:  return {6'b0, 1'b1, 1'b0, 1'b1, 8'b0};
      4'd6:  return {2'b00, 1'b1, 1'b0, 1'b1, 12'b0};
      4'd7:  return {9'b0, 1'b1, 2'b00, 3'b010, 2'b00};
      4'd8:  return {7'b0, 2'b11, 8'b0};
      4'd9:  return {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 3'b100, 2'b01};
      4'd10: return {9'b0, 1'b1, 2'b10, iop, 2'b00};
      4'd11: return {8'b0, 1'b1, 1'b1, 2'b10, iop, 2'b00};
      default: return 17'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got ill/to/st/ctl=%b required %b", tag, got, exp);
  endtask

  task automatic samp(input string tag, input logic [3:0] st, input logic ill, input logic to);
    exp_q.push_back({ill, to, st, exp_ctl(st, opcode, mem_ready)});
    #1;
    chk(tag, {illegal_op, mem_timeout, state_o, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
              MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource}, exp_q.pop_front());
  endtask

  task automatic step(input string tag, input logic [5:0] op, input logic rdy, input logic [3:0] st,
                      input logic ill = 1'b0, input logic to = 1'b0);
    @(negedge clk);
    opcode = op;
    mem_ready = rdy;
    samp(tag, st, ill, to);
  endtask

  task automatic run_inst(input string tag, input logic [5:0] op);
    step({tag, "_fetch"}, op, 1'b1, 4'd1);
    step({tag, "_decode"}, op, 1'b1, 4'd2);
    case (op)
      6'b000000: begin step({tag, "_exec"}, op, 1'b1, 4'd7); step({tag, "_wb"}, op, 1'b1, 4'd8); end
      6'b000100: step({tag, "_branch"}, op, 1'b1, 4'd9);
      6'b101011: begin step({tag, "_addr"}, op, 1'b1, 4'd3); step({tag, "_mw"}, op, 1'b1, 4'd6); end
      default: begin step({tag, "_exec"}, op, 1'b1, 4'd10); step({tag, "_wb"}, op, 1'b1, 4'd11); end
    endcase
  endtask

  initial begin
    step("rst0", 6'd0, 1'b1, 4'd0);
    step("rst1", 6'd0, 1'b1, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    samp("idle", 4'd0, 1'b0, 1'b0);
    run_inst("r", 6'b000000);
    // lw with three stalled MEM_READ cycles; the fourth answer coincides with watchdog expiry
    step("lw_fetch", 6'b100011, 1'b1, 4'd1);
    step("lw_decode", 6'b100011, 1'b1, 4'd2);
    step("lw_addr", 6'b100011, 1'b1, 4'd3);
    for (int i = 0; i < 3; i++) step("lw_wait", 6'b100011, 1'b0, 4'd4);
    step("lw_read", 6'b100011, 1'b1, 4'd4);
    step("lw_wb", 6'b100011, 1'b1, 4'd5);
    run_inst("sw", 6'b101011);
    run_inst("beq", 6'b000100);
    run_inst("addi", 6'b001000);
    run_inst("andi", 6'b001100);
    run_inst("ori", 6'b001101);
    run_inst("slti", 6'b001010);
    step("ill_fetch", 6'b111111, 1'b1, 4'd1);
    step("ill_decode", 6'b111111, 1'b1, 4'd2);
    step("ill_pulse", 6'b111111, 1'b0, 4'd1, 1'b1, 1'b0);
    run_inst("after_ill", 6'b000000);
    step("to_fetch", 6'b101011, 1'b1, 4'd1);
    step("to_decode", 6'b101011, 1'b1, 4'd2);
    step("to_addr", 6'b101011, 1'b1, 4'd3);
    for (int i = 0; i < 4; i++) step("to_wait", 6'b101011, 1'b0, 4'd6);
    step("to_pulse", 6'b101011, 1'b0, 4'd1, 1'b0, 1'b1);
    step("to_refetch", 6'b101011, 1'b1, 4'd1);
    step("rp_decode", 6'b101011, 1'b1, 4'd2);
    step("rp_addr", 6'b101011, 1'b1, 4'd3);
    for (int i = 0; i < 3; i++) step("rp_wait", 6'b101011, 1'b0, 4'd6);
    step("rp_done", 6'b101011, 1'b1, 4'd6);
    for (int i = 0; i < 4; i++) step("fto_wait", 6'b000000, 1'b0, 4'd1);
    step("fto_pulse", 6'b000000, 1'b1, 4'd1, 1'b0, 1'b1);
    step("fto_decode", 6'b000000, 1'b1, 4'd2);
    step("fto_exec", 6'b000000, 1'b1, 4'd7);
    step("fto_wb", 6'b000000, 1'b1, 4'd8);
    step("ar_fetch", 6'b100011, 1'b1, 4'd1);
    step("ar_decode", 6'b100011, 1'b1, 4'd2);
    step("ar_addr", 6'b100011, 1'b1, 4'd3);
    step("ar_wait", 6'b100011, 1'b0, 4'd4);
    #2 rst = 1'b1;
    samp("async_rst", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    samp("post_rst", 4'd0, 1'b0, 1'b0);
    run_inst("final", 6'b001000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style finite state machine that sequences a multi-cycle MIPS datapath.
- The datapath has shared memory, an instruction register (IR), a register file, one ALU and a PC.
- Supports the same instruction subset as the single-cycle decoder: R-type, lw, sw, beq, addi, andi, ori, slti.
- Memory states use a ready handshake guarded by a watchdog counter.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting on mem_ready before abort. 0 disables the watchdog.
- TO_W, 8: watchdog counter width. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory completed the current read or write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU zero in the datapath.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  IR load.
- MemToReg  out  1  register write data select: 1 = MDR.
- RegDst  out  1  destination select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- ALUOp  out  3  ALU operation, same encoding as the single-cycle decoder.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut.
- state_o  out  4  current state, for debug.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- mem_timeout  out  1  one-cycle pulse on a watchdog abort.

Behaviour:
- Reset: state = IDLE. All outputs 0, watchdog count 0. An async assert mid-instruction abandons the instruction; no write strobes are asserted while rst = 1.
- Outputs are decoded from the registered state. Exceptions: IRWrite, PCWrite and next-state leaving a wait state are additionally gated by mem_ready.
- Outputs not listed for a state are 0.
- ALUOp encoding: 010 = funct-driven, 011 = add, 100 = sub, 111 = and, 101 = or, 001 = slt.

States and transitions:
- IDLE (0): all outputs 0; goes to FETCH unconditionally.
- FETCH (1): IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=011, PCSource=00.
  - While mem_ready=0, stays in FETCH.
  - When mem_ready=1: IRWrite=1 and PCWrite=1 in that same cycle, then goes to DECODE.
- DECODE (2): ALUSrcA=0, ALUSrcB=11, ALUOp=011, which precomputes the branch target.
  - 100011 or 101011: goes to MEM_ADDR.
  - 000000: goes to EXEC_R.
  - 000100: goes to BRANCH.
  - 001000, 001100, 001101, 001010: goes to EXEC_I.
  - Any other opcode: goes to FETCH and pulses illegal_op in the next cycle.
- MEM_ADDR (3): ALUSrcA=1, ALUSrcB=10, ALUOp=011. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (4): IorD=1, MemRead=1. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB (5): RegDst=0, MemToReg=1, RegWrite=1. Goes to FETCH.
- MEM_WRITE (6): IorD=1, MemWrite=1, held high until mem_ready=1. Then goes to FETCH.
- EXEC_R (7): ALUSrcA=1, ALUSrcB=00, ALUOp=010. Goes to R_WB.
- R_WB (8): RegDst=1, RegWrite=1. Goes to FETCH.
- BRANCH (9): ALUSrcA=1, ALUSrcB=00, ALUOp=100, PCWriteCond=1, PCSource=01. Goes to FETCH.
- EXEC_I (10): ALUSrcA=1, ALUSrcB=10. ALUOp is 011 for addi, 111 for andi, 101 for ori, 001 for slti. Goes to I_WB.
- I_WB (11): RegDst=0, MemToReg=0, RegWrite=1. ALUOp and ALUSrc are held at their EXEC_I values. Goes to FETCH.

Watchdog:
- Counts cycles spent in FETCH, MEM_READ or MEM_WRITE with mem_ready=0. It clears on any state change.
- When the count reaches TIMEOUT_CYCLES-1 with mem_ready still 0, the FSM goes to FETCH and mem_timeout=1 in the next cycle.
  - No IRWrite, PCWrite or RegWrite occurs for the aborted access.
  - A timeout inside FETCH restarts the fetch, and the count clears.
- If mem_ready=1 in the same cycle the watchdog expires, mem_ready wins: normal transition, no timeout.
- Per-instruction cycle counts with mem_ready tied high: lw 5, sw 4, R 4, I 4, beq 3.

Decomposition:
- Package multicycle_pkg:
  - state encodings (4-bit, values as listed above);
  - opcode constants: OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI;
  - ALUOp constants: ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_AND, ALU_OR, ALU_SLT;
  - ALUSrcB select constants.
- Sub-module mem_watchdog: counter with TIMEOUT_CYCLES and TO_W parameters, inputs clk, rst, clear, waiting, mem_ready; output expire.

Test Plan:
- Reset, then release with mem_ready=1 and opcode=000000:
  - IDLE for 1 cycle;
  - FETCH with IRWrite=PCWrite=1;
  - DECODE, EXEC_R (ALUOp=010), R_WB (RegDst=1, RegWrite=1), back to FETCH;
  - state_o sequence 0, 1, 2, 7, 8, 1.
- lw (100011) with mem_ready held low 3 cycles in MEM_READ:
  - MemRead=1 and IorD=1 held for 4 cycles;
  - MEM_WB asserts MemToReg=1, RegWrite=1, RegDst=0.
- sw then beq:
  - sw: MemWrite=1 only in MEM_WRITE;
  - beq: BRANCH shows PCWriteCond=1, PCSource=01, ALUOp=100, RegWrite=0.
- Opcode sweep over addi, andi, ori, slti: EXEC_I ALUOp is 011, 111, 101, 001 respectively; I_WB RegWrite=1.
- Opcode 111111 at DECODE: return to FETCH, illegal_op=1 for exactly 1 cycle, no write strobes.
- TIMEOUT_CYCLES=4 with mem_ready=0 in MEM_WRITE:
  - abort to FETCH after 4 wait cycles;
  - mem_timeout pulses 1 cycle;
  - a repeat run with mem_ready=1 on the 4th cycle completes with no timeout.
- Assert rst asynchronously mid-MEM_READ: outputs go to 0 immediately and state_o=0.
